// File: rtl/ha_result_accumulator_if.sv
// Handshake bundle between the half-adder stage, the frame accumulator and the result sink.
interface ha_result_accumulator_if #(
   parameter int unsigned ACC_W = 4
);
   logic             IN_VALID;
   logic             IN_READY;
   logic             OUT;
   logic             CY;
   logic [ACC_W-1:0] SUM;
   logic             SUM_VALID;
   logic             SUM_READY;
   logic             FRAME_ERR;
   logic             OVF;

   modport master (
      output IN_VALID, OUT, CY, SUM_READY,
      input  IN_READY, SUM, SUM_VALID, FRAME_ERR, OVF
   );

   modport slave (
      input  IN_VALID, OUT, CY, SUM_READY,
      output IN_READY, SUM, SUM_VALID, FRAME_ERR, OVF
   );
endinterface

// File: rtl/ha_result_accumulator.sv
// Accumulates {CY,OUT} half-adder samples over a fixed frame and presents a saturating
// total, an illegal-code flag and an overflow flag through a valid/ready result port.
module ha_result_accumulator #(
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned ACC_W     = 4,
   parameter int unsigned CNT_W     = 4
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     CLEAR,
   ha_result_accumulator_if.slave   bus
);

   localparam logic [0:0]       ST_ACCUM = 1'b0;
   localparam logic [0:0]       ST_HOLD  = 1'b1;
   localparam int unsigned      SUM_W    = ACC_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
   localparam logic [ACC_W-1:0] ACC_MAX  = '1;

   logic [0:0]       state_q,     state_d;
   logic [ACC_W-1:0] acc_q,       acc_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             err_q,       err_d;
   logic             ovf_q,       ovf_d;
   logic [ACC_W-1:0] sum_q,       sum_d;
   logic             frame_err_q, frame_err_d;
   logic             res_ovf_q,   res_ovf_d;

   logic             in_ready_c;
   logic             accept_c;
   logic [1:0]       code_c;
   logic [SUM_W-1:0] sample_v_c;
   logic [SUM_W-1:0] acc_ext_c;
   logic [ACC_W-1:0] acc_sat_c;
   logic             err_upd_c;
   logic             ovf_upd_c;

   // Sample decode and saturating add; code 11 contributes nothing but marks the frame.
   always_comb begin
      in_ready_c = RST_N && (state_q == ST_ACCUM);
      accept_c   = bus.IN_VALID && in_ready_c;
      code_c     = {bus.CY, bus.OUT};
      sample_v_c = (code_c == 2'b11) ? '0 : SUM_W'(code_c);
      acc_ext_c  = SUM_W'(acc_q) + sample_v_c;
      acc_sat_c  = acc_ext_c[ACC_W] ? ACC_MAX : acc_ext_c[ACC_W-1:0];
      err_upd_c  = err_q | (code_c == 2'b11);
      ovf_upd_c  = ovf_q | acc_ext_c[ACC_W];
   end

   // Next-state logic; CLEAR outranks both accept and the result handshake.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      ovf_d       = ovf_q;
      sum_d       = sum_q;
      frame_err_d = frame_err_q;
      res_ovf_d   = res_ovf_q;

      if (CLEAR) begin
         state_d = ST_ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (accept_c) begin
                  acc_d = acc_sat_c;
                  err_d = err_upd_c;
                  ovf_d = ovf_upd_c;
                  if (cnt_q == CNT_LAST) begin
                     state_d     = ST_HOLD;
                     cnt_d       = '0;
                     sum_d       = acc_sat_c;
                     frame_err_d = err_upd_c;
                     res_ovf_d   = ovf_upd_c;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (bus.SUM_READY) begin
                  state_d = ST_ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  ovf_d   = 1'b0;
               end
            end
            default: begin
               state_d = ST_ACCUM;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= ST_ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
         sum_q       <= '0;
         frame_err_q <= 1'b0;
         res_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         ovf_q       <= ovf_d;
         sum_q       <= sum_d;
         frame_err_q <= frame_err_d;
         res_ovf_q   <= res_ovf_d;
      end
   end

   // IN_READY must drop combinationally while reset is held.
   assign bus.IN_READY  = in_ready_c;
   assign bus.SUM_VALID = (state_q == ST_HOLD);
   assign bus.SUM       = sum_q;
   assign bus.FRAME_ERR = frame_err_q;
   assign bus.OVF       = res_ovf_q;

endmodule

// File: tb/tb_ha_result_accumulator.sv
// Bench for ha_result_accumulator: directed frames from the test plan plus a random phase,
// all checked against a frame-level reference model.
module tb_ha_result_accumulator;

   localparam int FL   = 8;
   localparam int AW   = 4;
   localparam int CW   = 4;
   localparam int MAXV = (1 << AW) - 1;

   logic CLK;
   logic RST_N;
   logic CLEAR;

   ha_result_accumulator_if #(.ACC_W(AW)) bus ();

   ha_result_accumulator #(
      .FRAME_LEN (FL),
      .ACC_W     (AW),
      .CNT_W     (CW)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .CLEAR (CLEAR),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: unbounded running total, saturation applied only when reporting.
   bit         m_hold;
   int         m_cnt;
   int         m_total;
   bit         m_err;
   bit         m_known;
   int         e_sum;
   bit         e_err;
   bit         e_ovf;
   logic [1:0] m_code;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at %0t", nm, $time);
   endtask

   always @(posedge CLK) begin
      if (!RST_N) begin
         m_hold = 0; m_cnt = 0; m_total = 0; m_err = 0;
         e_sum = 0; e_err = 0; e_ovf = 0; m_known = 1;
      end else if (CLEAR) begin
         m_hold = 0; m_cnt = 0; m_total = 0; m_err = 0; m_known = 0;
      end else if (m_hold) begin
         if (bus.SUM_READY) begin
            m_hold = 0; m_cnt = 0; m_total = 0; m_err = 0;
         end
      end else if (bus.IN_VALID) begin
         m_code = {bus.CY, bus.OUT};
         if (m_code == 2'b11) m_err = 1;
         else m_total += int'(m_code);
         m_cnt++;
         if (m_cnt == FL) begin
            m_hold  = 1;
            e_sum   = (m_total > MAXV) ? MAXV : m_total;
            e_ovf   = (m_total > MAXV);
            e_err   = m_err;
            m_known = 1;
            m_cnt   = 0;
         end
      end
   end

   // Per-cycle compare, 1 time unit after the active edge.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         chk("in_ready", int'(bus.IN_READY), int'(RST_N && !m_hold));
         chk("sum_valid", int'(bus.SUM_VALID), int'(m_hold));
         if (m_known) begin
            chk("sum", int'(bus.SUM), e_sum);
            chk("frame_err", int'(bus.FRAME_ERR), int'(e_err));
            chk("ovf", int'(bus.OVF), int'(e_ovf));
         end
      end
   end

   task automatic send(input logic [1:0] code);
      int n;
      n = 0;
      @(negedge CLK);
      bus.IN_VALID = 1'b1;
      bus.CY  = code[1];
      bus.OUT = code[0];
      while (!bus.IN_READY && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) timeout("send");
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         bus.IN_VALID = 1'b0;
      end
   endtask

   task automatic frame(input logic [1:0] code);
      for (int i = 0; i < FL; i++) send(code);
   endtask

   task automatic expect_result(input string nm, input int s, input int fe, input int o);
      int n;
      n = 0;
      @(negedge CLK);
      chk({nm, "_latency"}, int'(bus.SUM_VALID), 1);
      while (!bus.SUM_VALID && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) timeout({nm, "_result"});
      chk({nm, "_sum"}, int'(bus.SUM), s);
      chk({nm, "_frame_err"}, int'(bus.FRAME_ERR), fe);
      chk({nm, "_ovf"}, int'(bus.OVF), o);
      chk({nm, "_held_ready"}, int'(bus.IN_READY), 0);
   endtask

   task automatic handshake(input string nm);
      @(negedge CLK);
      bus.SUM_READY = 1'b1;
      bus.IN_VALID  = 1'b0;
      @(negedge CLK);
      chk({nm, "_hs_valid"}, int'(bus.SUM_VALID), 0);
      chk({nm, "_hs_ready"}, int'(bus.IN_READY), 1);
      bus.SUM_READY = 1'b0;
   endtask

   initial begin
      RST_N = 1'b0;
      CLEAR = 1'b0;
      bus.IN_VALID  = 1'b0;
      bus.OUT       = 1'b0;
      bus.CY        = 1'b0;
      bus.SUM_READY = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_in_ready", int'(bus.IN_READY), 0);
      chk("rst_sum_valid", int'(bus.SUM_VALID), 0);
      chk("rst_sum", int'(bus.SUM), 0);
      chk("rst_flags", int'({bus.FRAME_ERR, bus.OVF}), 0);
      RST_N = 1'b1;

      // Plain frame, then saturation
      frame(2'b01);
      expect_result("ones", 8, 0, 0);
      handshake("ones");
      chk("retain_sum", int'(bus.SUM), 8);
      frame(2'b10);
      expect_result("twos", 15, 0, 1);
      handshake("twos");

      // Gapped samples
      for (int r = 0; r < 2; r++) begin
         send(2'b00); idle(1);
         send(2'b01); idle(3);
         send(2'b10); idle(2);
         send(2'b01); idle(1);
      end
      expect_result("gaps", 8, 0, 0);
      handshake("gaps");

      // Back-pressure with IN_VALID held high
      frame(2'b01);
      expect_result("bp", 8, 0, 0);
      repeat (5) begin
         @(negedge CLK);
         chk("bp_valid", int'(bus.SUM_VALID), 1);
         chk("bp_sum", int'(bus.SUM), 8);
         chk("bp_ready", int'(bus.IN_READY), 0);
      end
      handshake("bp");
      frame(2'b01);
      expect_result("bp_next", 8, 0, 0);
      handshake("bp_next");

      // Illegal code frame, then a clean one
      send(2'b01); send(2'b01); send(2'b11);
      for (int i = 0; i < 5; i++) send(2'b01);
      expect_result("err", 7, 1, 0);
      handshake("err");
      frame(2'b01);
      expect_result("clean", 8, 0, 0);
      handshake("clean");

      // CLEAR mid-frame with a discarded sample, then reset mid-frame
      for (int i = 0; i < 4; i++) send(2'b10);
      @(negedge CLK);
      CLEAR = 1'b1; bus.IN_VALID = 1'b1; bus.CY = 1'b1; bus.OUT = 1'b0;
      @(negedge CLK);
      CLEAR = 1'b0; bus.IN_VALID = 1'b0;
      frame(2'b01);
      expect_result("clear", 8, 0, 0);
      handshake("clear");
      for (int i = 0; i < 4; i++) send(2'b10);
      @(negedge CLK);
      RST_N = 1'b0; bus.IN_VALID = 1'b1;
      #1;
      chk("rst_mid_ready", int'(bus.IN_READY), 0);
      @(negedge CLK);
      RST_N = 1'b1; bus.IN_VALID = 1'b0;
      frame(2'b01);
      expect_result("rstmid", 8, 0, 0);

      // CLEAR while holding a result
      @(negedge CLK);
      CLEAR = 1'b1;
      @(negedge CLK);
      CLEAR = 1'b0;
      chk("clear_hold_valid", int'(bus.SUM_VALID), 0);
      chk("clear_hold_ready", int'(bus.IN_READY), 1);

      // Random phase
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK);
         RST_N         = ($urandom_range(199) != 0);
         CLEAR         = ($urandom_range(59) == 0);
         bus.IN_VALID  = ($urandom_range(9) < 7);
         bus.CY        = 1'($urandom_range(1));
         bus.OUT       = 1'($urandom_range(1));
         bus.SUM_READY = ($urandom_range(1) == 1);
      end
      @(negedge CLK);
      RST_N = 1'b1; CLEAR = 1'b0; bus.IN_VALID = 1'b0; bus.SUM_READY = 1'b0;
      repeat (2) @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

endmodule
